keypad_encoder: RTL and testbench
=================================

// Module: keypad_encoder
// PURPOSE
//   Front-end of the microwave controller. Converts the 10-key decimal keypad (one line per digit) into a 4-bit BCD code.
//   Issues a one-cycle active-low load strobe for each new key press.
//   Also divides the 100 Hz system clock down to a 1 Hz square wave that drives the countdown timer.
//   Sits between the keypad and the minutes/seconds counter loading logic.
// PARAMETERS
//   DIV      100  clock cycles per pgt_1Hz period (must be even, >=2)
//   KEYS     10   number of keypad lines (digits 0..KEYS-1; fixed at 10 for BCD)
// PORTS
//   Hz_100_clock  in   1   system clock, 100 Hz; all logic on its rising edge
//   reset         in   1   synchronous, active-high reset
//   teclado       in   10  keypad lines; bit k high = digit k pressed
//   enablen       in   1   active-low enable for key capture
//   D             out  4   BCD code of the captured key (0..9)
//   loadn         out  1   active-low load strobe, one cycle per new press
//   pgt_1Hz       out  1   1 Hz square wave; its rising edge is the timer tick
// BEHAVIOUR
//   Clock and reset:
//   - One clock (Hz_100_clock); reset is synchronous and active-high.
//   - Reset has priority over every other input.
//   - Reset values: D=4'd0, loadn=1, pgt_1Hz=0, divider count=0, previous-key register=0.
//   Key encoding (combinational):
//   - Code = index of the highest set bit of teclado (priority encoder, bit 9 wins).
//   - valid = |teclado.
//   Key capture (registered, 1-cycle latency):
//   - A rising edge samples teclado into key_prev every cycle.
//   - new_press = valid & (teclado != key_prev).
//     This covers a press after idle and a change to a different key combination.
//   - If enablen==0 and new_press: D <= code, loadn <= 0.
//   - Otherwise: loadn <= 1 and D holds its last value.
//   - Holding a key produces exactly one loadn pulse, one cycle wide.
//   - Releasing all keys (teclado==0) produces no pulse and leaves D unchanged.
//   - enablen==1 suppresses capture: no pulse, D frozen. key_prev still tracks teclado.
//     As a result, a key held across enablen 1->0 does not pulse.
//   - Multiple keys pressed: the priority code is captured. A change in the set counts as a new press.
//   1 Hz divider:
//   - Counter runs 0..DIV-1, then wraps to 0.
//   - It runs regardless of enablen.
//   - pgt_1Hz is registered: 0 while count < DIV/2, 1 while count >= DIV/2.
//   - Result is a 50% duty cycle with period DIV clocks.
//   - First rising edge of pgt_1Hz occurs DIV/2 cycles after reset is released.
//   - Reset mid-period restarts the count at 0 with pgt_1Hz=0.
// TESTING
//   1. reset=1 for 2 cycles -> D=0, loadn=1, pgt_1Hz=0; hold teclado=0 for 10 cycles -> loadn stays 1.
//   2. enablen=0; step teclado through 10'b1 to 10'b1000000000, one bit per 3 cycles.
//      -> D follows 0..9, one cycle after each change; exactly one 1-cycle loadn=0 per step.
//   3. enablen=0; teclado=10'b0000100100 -> D=5, one loadn pulse.
//      Then change to 10'b0000000100 -> D=2, another pulse.
//   4. enablen=1; press key 7 -> no loadn pulse, D unchanged.
//      Release; set enablen=0; press 7 -> D=7, one pulse.
//   5. Run 250 cycles after reset -> pgt_1Hz rises at cycles 50, 150, 250 and falls at 100, 200 (50% duty).
//   6. Assert reset while key 3 is held and the divider is at count 70 -> next cycle D=0, loadn=1, pgt_1Hz=0, count=0.
//      Holding key 3 after reset yields exactly one pulse.

Source files
------------

// File: rtl/keypad_encoder.sv
// Keypad front-end: priority-encodes the 10-line decimal keypad to BCD with a one-cycle
// active-low load strobe per new press, and divides the system clock to a 1 Hz square wave.
module keypad_encoder #(
    parameter int unsigned DIV  = 100,
    parameter int unsigned KEYS = 10
) (
    input  logic            Hz_100_clock,
    input  logic            reset,
    input  logic [KEYS-1:0] teclado,
    input  logic            enablen,
    output logic [3:0]      D,
    output logic            loadn,
    output logic            pgt_1Hz
);

    localparam int unsigned CntW = $clog2(DIV);
    localparam logic [CntW-1:0] CntMax  = CntW'(DIV - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(DIV / 2);

    logic [KEYS-1:0] key_prev_q, key_prev_d;
    logic [3:0]      d_q, d_d;
    logic            loadn_q, loadn_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pgt_q, pgt_d;

    logic [3:0]      code;
    logic            valid;
    logic            new_press;

    // Ascending scan so the highest pressed digit wins.
    always_comb begin
        code = 4'd0;
        for (int k = 0; k < KEYS; k++) begin
            if (teclado[k]) begin
                code = 4'(k);
            end
        end
    end

    assign valid     = |teclado;
    assign new_press = valid && (teclado != key_prev_q);

    always_comb begin
        key_prev_d = teclado;
        d_d        = d_q;
        loadn_d    = 1'b1;
        if (!enablen && new_press) begin
            d_d     = code;
            loadn_d = 1'b0;
        end
    end

    // pgt follows the next count so it stays aligned with cnt_q in the same cycle.
    always_comb begin
        cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        pgt_d = (cnt_d >= CntHalf);
    end

    always_ff @(posedge Hz_100_clock) begin
        if (reset) begin
            key_prev_q <= '0;
            d_q        <= 4'd0;
            loadn_q    <= 1'b1;
            cnt_q      <= '0;
            pgt_q      <= 1'b0;
        end else begin
            key_prev_q <= key_prev_d;
            d_q        <= d_d;
            loadn_q    <= loadn_d;
            cnt_q      <= cnt_d;
            pgt_q      <= pgt_d;
        end
    end

    assign D       = d_q;
    assign loadn   = loadn_q;
    assign pgt_1Hz = pgt_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: vector table for key capture, hand-written sequences
// for the divider timing and for reset in mid-period with a key held.
module tb_keypad_encoder;

    logic       clk;
    logic       reset;
    logic [9:0] teclado;
    logic       enablen;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1Hz;

    int errors = 0;
    int checks = 0;

    keypad_encoder #(
        .DIV  (100),
        .KEYS (10)
    ) dut (
        .Hz_100_clock (clk),
        .reset        (reset),
        .teclado      (teclado),
        .enablen      (enablen),
        .D            (D),
        .loadn        (loadn),
        .pgt_1Hz      (pgt_1Hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] tec;
        logic       en_n;
        logic [3:0] exp_d;
        logic       exp_loadn;
    } vec_t;

    vec_t vecs[64];
    int   n_vec = 0;

    task automatic add(input logic [9:0] tec, input logic en_n, input logic [3:0] d,
                       input logic ld);
        vecs[n_vec].tec       = tec;
        vecs[n_vec].en_n      = en_n;
        vecs[n_vec].exp_d     = d;
        vecs[n_vec].exp_loadn = ld;
        n_vec++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        reset   = 1'b1;
        teclado = '0;
        enablen = 1'b0;

        // Key steps 0..9, one bit per 3 cycles.
        for (int k = 0; k < 10; k++) begin
            add(10'(1) << k, 1'b0, 4'(k), 1'b0);
            add(10'(1) << k, 1'b0, 4'(k), 1'b1);
            add(10'(1) << k, 1'b0, 4'(k), 1'b1);
        end
        // Two keys together, then drop to a subset.
        add(10'b0000100100, 1'b0, 4'd5, 1'b0);
        add(10'b0000100100, 1'b0, 4'd5, 1'b1);
        add(10'b0000100100, 1'b0, 4'd5, 1'b1);
        add(10'b0000000100, 1'b0, 4'd2, 1'b0);
        add(10'b0000000100, 1'b0, 4'd2, 1'b1);
        // Release leaves D unchanged, no pulse.
        add(10'b0000000000, 1'b0, 4'd2, 1'b1);
        // Disabled press of 7 is ignored.
        add(10'b0010000000, 1'b1, 4'd2, 1'b1);
        add(10'b0010000000, 1'b1, 4'd2, 1'b1);
        add(10'b0000000000, 1'b1, 4'd2, 1'b1);
        add(10'b0000000000, 1'b0, 4'd2, 1'b1);
        add(10'b0010000000, 1'b0, 4'd7, 1'b0);
        add(10'b0010000000, 1'b0, 4'd7, 1'b1);
        // Key held across enablen 1->0 does not pulse.
        add(10'b0000000000, 1'b0, 4'd7, 1'b1);
        add(10'b0000010000, 1'b1, 4'd7, 1'b1);
        add(10'b0000010000, 1'b0, 4'd7, 1'b1);
        add(10'b0000010000, 1'b0, 4'd7, 1'b1);

        // Reset and idle.
        do_reset(2);
        chk("reset D", D, 0);
        chk("reset loadn", loadn, 1);
        chk("reset pgt", pgt_1Hz, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (loadn == 1'b0) pulses++;
        end
        chk("idle pulses", pulses, 0);
        chk("idle D", D, 0);

        // Vector table.
        for (int i = 0; i < n_vec; i++) begin
            teclado = vecs[i].tec;
            enablen = vecs[i].en_n;
            tick();
            chk($sformatf("vec%0d D", i), D, vecs[i].exp_d);
            chk($sformatf("vec%0d loadn", i), loadn, vecs[i].exp_loadn);
        end

        // Divider: after edge n since reset release, count = n % 100.
        teclado = '0;
        enablen = 1'b0;
        do_reset(2);
        chk("div reset pgt", pgt_1Hz, 0);
        for (int n = 1; n <= 250; n++) begin
            tick();
            chk($sformatf("pgt cycle %0d", n), pgt_1Hz, ((n % 100) >= 50) ? 1 : 0);
        end

        // Reset at count 70 with key 3 held.
        teclado = 10'b0000001000;
        do_reset(1);
        for (int n = 1; n <= 70; n++) tick();
        chk("pre-reset pgt", pgt_1Hz, 1);
        chk("pre-reset D", D, 3);
        reset = 1'b1;
        tick();
        chk("mid reset D", D, 0);
        chk("mid reset loadn", loadn, 1);
        chk("mid reset pgt", pgt_1Hz, 0);
        reset  = 1'b0;
        pulses = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (loadn == 1'b0) pulses++;
            if (n == 1) chk("post reset loadn", loadn, 0);
            if (n == 1) chk("post reset D", D, 3);
            if (n == 49 || n == 50) begin
                chk($sformatf("post reset pgt %0d", n), pgt_1Hz, (n >= 50) ? 1 : 0);
            end
        end
        chk("post reset pulses", pulses, 1);
        chk("post reset D hold", D, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
